// File: rtl/muldiv_unit_if.sv
// Core-side request/response bundle for the iterative multiply/divide unit.
// The core drives start/op/operands/flush; the unit answers with busy/done/result.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: shift-add multiply, restoring divide, one bit per cycle.
// Latency WIDTH+1 cycles to done (1 on div-by-zero/overflow); start is ignored while busy, flush aborts.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Operand decode at capture time
    logic             a_sgn, b_sgn, a_neg, b_neg, res_neg;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        a_sgn    = (bus.op == 3'b001) | (bus.op == 3'b010) | (bus.op[2] & ~bus.op[0]);
        b_sgn    = (bus.op == 3'b001) | (bus.op[2] & ~bus.op[0]);
        a_neg    = a_sgn & bus.a[WIDTH-1];
        b_neg    = b_sgn & bus.b[WIDTH-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        // Remainder follows the dividend; everything else follows the product/quotient sign.
        res_neg  = (bus.op[2] & bus.op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = bus.op[2] & (bus.b == '0);
        div_ovf  = bus.op[2] & ~bus.op[0] & (&bus.b) &
                   (bus.a == {1'b1, {(WIDTH-1){1'b0}}});
        if (div_zero) begin
            fast_res = bus.op[1] ? bus.a : '1;
        end else begin
            fast_res = bus.op[1] ? '0 : bus.a;
        end
    end

    // One radix-2 step on the shared accumulator {hi, lo}
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mb_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mb_q};
        div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        step      = op_q[2] ? div_next : mul_next;
    end

    // Sign fix-up applied to the value produced by the final step
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo, rem, fin;

    always_comb begin
        prod_s = neg_q ? -step : step;
        quo    = step[WIDTH-1:0];
        rem    = step[2*WIDTH-1:WIDTH];
        if (op_q[2]) begin
            if (op_q[1]) begin
                fin = neg_q ? -rem : rem;
            end else begin
                fin = neg_q ? -quo : quo;
            end
        end else begin
            fin = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;

        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            acc_d = step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                state_d  = S_DONE;
                cnt_d    = '0;
                result_d = fin;
            end
        end else if (bus.start) begin
            op_d  = bus.op;
            mb_d  = b_mag;
            acc_d = {{WIDTH{1'b0}}, a_mag};
            neg_d = res_neg;
            cnt_d = '0;
            if (div_zero | div_ovf) begin
                state_d  = S_DONE;
                result_d = fast_res;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit with a start/busy/done handshake, parametrised in WIDTH.
- Sits beside the single-cycle ALU. The core stalls on busy and writes result to the regfile on done.
- Extends execute capability from single-cycle ALU ops to multi-cycle M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Adds a flush input for pipeline-redirect abort.

Parameters:
WIDTH, 32, operand/result width in bits (even, >=8)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only when state is IDLE or DONE
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  WIDTH  rs1 operand, captured on accepted start
b  input  WIDTH  rs2 operand, captured on accepted start
flush  input  1  abort current operation
busy  output  1  high in RUN state
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  result; holds until the next done

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, done=0, result=0.
  - Counter and internal registers cleared.
  - Reset mid-RUN discards the operation; no done.
- States and transitions:
  - IDLE: on start, capture op/a/b, go to RUN (or to DONE via fast path).
  - RUN: one radix-2 step per cycle; after exactly WIDTH steps, go to DONE.
  - DONE: done=1 for this cycle only. Next state is IDLE, or RUN/DONE if start=1 (back-to-back accept).
- Latency: start accepted on edge k -> busy=1 from cycle k+1 to k+WIDTH -> done=1 in cycle k+WIDTH+1.
- start while busy is ignored; operands are not re-captured.
- Signed handling:
  - On capture, store the magnitudes of signed operands plus the result sign.
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: both unsigned.
  - Negation is applied on the RUN->DONE edge.
- Multiply:
  - Shift-add into a 2*WIDTH accumulator.
  - MUL returns the low WIDTH bits of the product; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide:
  - Restoring shift-subtract producing quotient and remainder.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a). Truncation toward zero.
- Fast path (go to DONE on the next edge, busy never asserts):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (a = most negative, b = -1): DIV = a, REM = 0.
- result register:
  - Updated only on entry to DONE and stable through DONE and after.
  - The DONE-cycle value must equal the final value.
- Flush:
  - flush=1 at any edge forces IDLE; busy drops next cycle; no done; result retains its old value.
  - flush and start in the same cycle: flush wins, start is dropped.
- Counter: CNT_W bits, counts 0..WIDTH-1, cleared on accept and on flush.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> done at cycle 33 after start, result=0xFFFFFFEB; busy high exactly 32 cycles.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5; DIV a=0x80000000, b=-1 -> 0x80000000; REM same operands -> 0. All with done one cycle after start, busy never high.
- flush at RUN cycle 10 -> busy=0 next cycle, no done, result unchanged. Then start MUL 3*4 -> 12. Start asserted during busy has no effect.
- rst low mid-RUN -> outputs 0 immediately (async). Back-to-back: start held in DONE cycle -> second op accepted, two done pulses 33 cycles apart. WIDTH=16 regression: MUL 0x00FF*0x0101 -> 0xFFFF.
